// File: rtl/dircc_types_pkg.sv
// Shared DiRCC types: network address layout and fanout scheduler state encoding.
package dircc_types_pkg;

    typedef struct packed {
        logic [31:0] hw_addr;
        logic [15:0] sw_addr;
        logic [7:0]  port;
        logic [7:0]  flag;
    } address_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } fanout_state_t;

    function automatic logic [31:0] clamp_targets(input logic [31:0] num,
                                                  input logic [31:0] max_targets);
        return (num > max_targets) ? max_targets : num;
    endfunction

endpackage

// File: rtl/dircc_fanout_scheduler_if.sv
// Handshake bundle between the fanout scheduler (master) and the device/NoC side (slave).
interface dircc_fanout_scheduler_if #(
    parameter int DEVICES     = 1,
    parameter int OUT_PORTS   = 1,
    parameter int MAX_TARGETS = 4,
    parameter int PAYLOAD_W   = 28
);
    import dircc_types_pkg::*;

    localparam int N      = DEVICES * OUT_PORTS;
    localparam int DEV_W  = $clog2(DEVICES) + 1;
    localparam int PORT_W = $clog2(OUT_PORTS) + 1;
    localparam int TGT_W  = $clog2(MAX_TARGETS) + 1;

    logic [N-1:0]         rts_i;
    logic [N-1:0]         rts_ack_o;
    logic [DEV_W-1:0]     sel_dev_o;
    logic [PORT_W-1:0]    sel_port_o;
    logic [TGT_W-1:0]     tgt_idx_o;
    logic [PAYLOAD_W-1:0] payload_i;
    logic [31:0]          tgt_num_i;
    address_t             tgt_addr_i;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    address_t             tx_dest_o;
    address_t             tx_src_o;
    logic [PAYLOAD_W-1:0] tx_payload_o;
    logic                 busy_o;

    modport master (
        input  rts_i, payload_i, tgt_num_i, tgt_addr_i, tx_ready_i,
        output rts_ack_o, sel_dev_o, sel_port_o, tgt_idx_o,
               tx_valid_o, tx_dest_o, tx_src_o, tx_payload_o, busy_o
    );

    modport slave (
        output rts_i, payload_i, tgt_num_i, tgt_addr_i, tx_ready_i,
        input  rts_ack_o, sel_dev_o, sel_port_o, tgt_idx_o,
               tx_valid_o, tx_dest_o, tx_src_o, tx_payload_o, busy_o
    );

endinterface

// File: rtl/dircc_rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or after ptr, wrapping past N-1.
module dircc_rr_arbiter #(
    parameter int N = 1,
    localparam int IW = $clog2(N) + 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant
);

    // Padding lets any IW-bit index address the request vector without a range fault.
    logic [(2**IW)-1:0] w_req_pad;
    logic [IW-1:0]      w_cand [N];
    logic [N-1:0]       w_rot_req;

    assign w_req_pad = (2**IW)'(req);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] w_sum;
            assign w_sum         = {1'b0, ptr} + (IW+1)'(gi);
            assign w_cand[gi]    = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
            assign w_rot_req[gi] = w_req_pad[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                valid     = 1'b1;
                grant_idx = w_cand[i];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (valid) begin
            grant = N'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/dircc_fanout_scheduler.sv
// Per-thread send scheduler: round-robin over (device, port) requests, one packet per fanout target.
// Optional DIRCC_FANOUT_STATS_EN adds sent_count_o, a wrapping count of accepted packets.
module dircc_fanout_scheduler #(
    parameter int          DEVICES     = 1,
    parameter int          OUT_PORTS   = 1,
    parameter int          MAX_TARGETS = 4,
    parameter int          PAYLOAD_W   = 28,
    parameter logic [31:0] THREAD_ID   = 32'h0
) (
    input  logic clk,
    input  logic reset_n,
    dircc_fanout_scheduler_if.master bus
`ifdef DIRCC_FANOUT_STATS_EN
    ,
    output logic [31:0] sent_count_o
`endif
);
    import dircc_types_pkg::*;

    localparam int N      = DEVICES * OUT_PORTS;
    localparam int SEL_W  = $clog2(N) + 1;
    localparam int DEV_W  = $clog2(DEVICES) + 1;
    localparam int PORT_W = $clog2(OUT_PORTS) + 1;
    localparam int TGT_W  = $clog2(MAX_TARGETS) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_SEND  = SEND;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]           r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [N-1:0]         r_grant;
    logic [SEL_W-1:0]     r_rr_ptr;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [TGT_W-1:0]     r_num;
    logic [TGT_W-1:0]     r_tgt_idx;

    logic                 w_grant_valid;
    logic [SEL_W-1:0]     w_grant_idx;
    logic [N-1:0]         w_grant;
    logic [TGT_W-1:0]     w_num_clamped;
    logic                 w_sending;
    logic [31:0]          w_sel_dev32;
    logic [31:0]          w_sel_port32;
    address_t             w_src;

    dircc_rr_arbiter #(.N(N)) u_arb (
        .req       (bus.rts_i),
        .ptr       (r_rr_ptr),
        .valid     (w_grant_valid),
        .grant_idx (w_grant_idx),
        .grant     (w_grant)
    );

    assign w_num_clamped = TGT_W'(clamp_targets(bus.tgt_num_i, 32'(MAX_TARGETS)));
    assign w_sending     = (r_state == ST_SEND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_payload <= '0;
            r_num     <= '0;
            r_tgt_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_sel   <= w_grant_idx;
                        r_grant <= w_grant;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_payload <= bus.payload_i;
                    r_num     <= w_num_clamped;
                    r_tgt_idx <= '0;
                    r_state   <= (w_num_clamped == '0) ? ST_DONE : ST_SEND;
                end
                ST_SEND: begin
                    // The index only moves on a handshake, so the looked-up destination holds under stall.
                    if (bus.tx_ready_i) begin
                        if (r_tgt_idx == r_num - TGT_W'(1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_tgt_idx <= r_tgt_idx + TGT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_rr_ptr  <= (r_sel == SEL_W'(N - 1)) ? '0 : r_sel + SEL_W'(1);
                    r_tgt_idx <= '0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DIRCC_FANOUT_STATS_EN
    logic [31:0] r_sent_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sent_count <= '0;
        end else if (w_sending && bus.tx_ready_i) begin
            r_sent_count <= r_sent_count + 32'd1;
        end
    end

    assign sent_count_o = r_sent_count;
`endif

    assign w_sel_dev32  = 32'(r_sel) / 32'(OUT_PORTS);
    assign w_sel_port32 = 32'(r_sel) % 32'(OUT_PORTS);

    always_comb begin
        w_src         = '0;
        w_src.hw_addr = THREAD_ID;
        w_src.sw_addr = 16'(w_sel_dev32);
        w_src.port    = 8'(w_sel_port32);
    end

    assign bus.rts_ack_o    = (r_state == ST_DONE) ? r_grant : '0;
    assign bus.sel_dev_o    = DEV_W'(w_sel_dev32);
    assign bus.sel_port_o   = PORT_W'(w_sel_port32);
    assign bus.tgt_idx_o    = r_tgt_idx;
    assign bus.tx_valid_o   = w_sending;
    assign bus.tx_dest_o    = w_sending ? bus.tgt_addr_i : '0;
    assign bus.tx_src_o     = w_sending ? w_src : '0;
    assign bus.tx_payload_o = w_sending ? r_payload : '0;
    assign bus.busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dircc_fanout_scheduler.sv
// Self-checking bench for dircc_fanout_scheduler against a queue-based fanout model.
module tb_dircc_fanout_scheduler;
    import dircc_types_pkg::*;

    localparam int D  = 4;
    localparam int P  = 1;
    localparam int MT = 4;
    localparam int PW = 28;
    localparam int N  = D * P;
    localparam logic [31:0] TID = 32'h0000_0005;

    typedef struct packed {
        address_t      dest;
        logic [PW-1:0] payload;
        address_t      src;
    } pkt_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dircc_fanout_scheduler_if #(.DEVICES(D), .OUT_PORTS(P), .MAX_TARGETS(MT), .PAYLOAD_W(PW)) bus_if ();

`ifdef DIRCC_FANOUT_STATS_EN
    logic [31:0] sent_count;
`endif

    dircc_fanout_scheduler #(
        .DEVICES(D), .OUT_PORTS(P), .MAX_TARGETS(MT), .PAYLOAD_W(PW), .THREAD_ID(TID)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
`ifdef DIRCC_FANOUT_STATS_EN
        ,
        .sent_count_o (sent_count)
`endif
    );

    // Device-side tables answered combinationally from the scheduler's selection.
    logic [PW-1:0] pay_tab [N];
    logic [31:0]   num_tab [N];
    address_t      addr_tab [N][MT];
    int            lut_s;
    int            lut_t;

    assign lut_s = int'(bus_if.sel_dev_o) * P + int'(bus_if.sel_port_o);
    assign lut_t = int'(bus_if.tgt_idx_o);

    always_comb begin
        bus_if.payload_i  = '0;
        bus_if.tgt_num_i  = '0;
        bus_if.tgt_addr_i = '0;
        if (lut_s < N) begin
            bus_if.payload_i = pay_tab[lut_s];
            bus_if.tgt_num_i = num_tab[lut_s];
            if (lut_t < MT) bus_if.tgt_addr_i = addr_tab[lut_s][lut_t];
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   model_ptr;
    bit   rand_ready;
    int   stall_lo, stall_hi;
    bit   timed_out;
    pkt_t obs_pkt[$];
    int   obs_pkt_cyc[$];
    int   obs_ack[$];
    int   obs_ack_cyc[$];
    pkt_t exp_pkt[$];
    int   exp_ack[$];
    address_t dest_at [64];
    logic     valid_at [64];

    function automatic address_t mk_addr(input logic [31:0] hw);
        address_t a;
        a = '0;
        a.hw_addr = hw;
        return a;
    endfunction

    function automatic address_t src_of(input int g);
        address_t a;
        a = '0;
        a.hw_addr = TID;
        a.sw_addr = 16'(g / P);
        a.port    = 8'(g % P);
        return a;
    endfunction

    // Reference: serve requesters in rotating order; each sends min(num, MT) packets then is acked.
    function automatic void build_expected(input logic [N-1:0] mask);
        logic [N-1:0] m;
        int g, c, cnt;
        pkt_t p;
        m = mask;
        exp_pkt.delete();
        exp_ack.delete();
        while (m != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                c = (model_ptr + k) % N;
                if (g < 0 && m[c]) g = c;
            end
            cnt = (num_tab[g] > MT) ? MT : int'(num_tab[g]);
            for (int k = 0; k < cnt; k++) begin
                p.dest = addr_tab[g][k];
                p.payload = pay_tab[g];
                p.src = src_of(g);
                exp_pkt.push_back(p);
            end
            exp_ack.push_back(g);
            m[g] = 1'b0;
            model_ptr = (g + 1) % N;
        end
    endfunction

    task automatic step();
        pkt_t p;
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ready) bus_if.tx_ready_i = ($urandom_range(0, 3) != 0);
        else            bus_if.tx_ready_i = !(cyc >= stall_lo && cyc < stall_hi);
        #1;
        if (cyc < 64) begin
            valid_at[cyc] = bus_if.tx_valid_o;
            dest_at[cyc]  = bus_if.tx_dest_o;
        end
        if (bus_if.tx_valid_o && bus_if.tx_ready_i) begin
            p.dest = bus_if.tx_dest_o;
            p.payload = bus_if.tx_payload_o;
            p.src = bus_if.tx_src_o;
            obs_pkt.push_back(p);
            obs_pkt_cyc.push_back(cyc);
            $display("cyc %0d: packet dest=%h src=%h payload=%h", cyc, p.dest, p.src, p.payload);
        end
        for (int i = 0; i < N; i++) begin
            if (bus_if.rts_ack_o[i]) begin
                obs_ack.push_back(i);
                obs_ack_cyc.push_back(cyc);
                bus_if.rts_i[i] = 1'b0;
                $display("cyc %0d: ack requester %0d", cyc, i);
            end
        end
    endtask

    task automatic clear_obs();
        obs_pkt.delete();
        obs_pkt_cyc.delete();
        obs_ack.delete();
        obs_ack_cyc.delete();
        for (int i = 0; i < 64; i++) begin
            valid_at[i] = 1'b0;
            dest_at[i]  = '0;
        end
        cyc = 0;
        timed_out = 1'b0;
    endtask

    task automatic run(input logic [N-1:0] mask, input int budget);
        clear_obs();
        build_expected(mask);
        bus_if.rts_i = mask;
        while (obs_ack.size() < exp_ack.size() && cyc < budget) step();
        if (obs_ack.size() < exp_ack.size()) timed_out = 1'b1;
        step();
    endtask

    task automatic do_reset();
        bus_if.rts_i = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic set_basic_tables();
        for (int i = 0; i < N; i++) begin
            num_tab[i] = 32'd0;
            pay_tab[i] = '0;
            for (int k = 0; k < MT; k++) addr_tab[i][k] = '0;
        end
        num_tab[0]     = 32'd4;
        pay_tab[0]     = {13'd1, 15'd10};
        addr_tab[0][0] = mk_addr(32'h0000_0001);
        addr_tab[0][1] = mk_addr(32'h0001_0000);
        addr_tab[0][2] = mk_addr(32'h0001_0002);
        addr_tab[0][3] = mk_addr(32'h0002_0001);
    endtask

    task automatic test_reset();
        bus_if.rts_i = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (bus_if.busy_o !== 1'b0 || bus_if.tx_valid_o !== 1'b0)
            $display("FAIL reset_busy_valid: got busy=%b valid=%b, expected 0/0", bus_if.busy_o, bus_if.tx_valid_o);
        checks++;
        if (bus_if.rts_ack_o !== '0 || bus_if.tgt_idx_o !== '0 || bus_if.sel_dev_o !== '0)
            $display("FAIL reset_sel: got ack=%b idx=%0d dev=%0d, expected 0", bus_if.rts_ack_o, bus_if.tgt_idx_o, bus_if.sel_dev_o);
        checks++;
        if (bus_if.tx_dest_o !== '0 || bus_if.tx_src_o !== '0 || bus_if.tx_payload_o !== '0)
            $display("FAIL reset_tx: got dest=%h src=%h pay=%h, expected 0", bus_if.tx_dest_o, bus_if.tx_src_o, bus_if.tx_payload_o);
        if (bus_if.busy_o !== 1'b0 || bus_if.tx_valid_o !== 1'b0 || bus_if.rts_ack_o !== '0 ||
            bus_if.tgt_idx_o !== '0 || bus_if.sel_dev_o !== '0 || bus_if.tx_dest_o !== '0 ||
            bus_if.tx_src_o !== '0 || bus_if.tx_payload_o !== '0) errors++;
        reset_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_basic();
        set_basic_tables();
        run(4'b0001, 40);
        checks++;
        if (timed_out || obs_pkt.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d packets (timeout=%0b), expected 4", obs_pkt.size(), timed_out);
        end
        for (int i = 0; i < obs_pkt.size() && i < exp_pkt.size(); i++) begin
            checks++;
            if (obs_pkt[i] !== exp_pkt[i] || obs_pkt_cyc[i] != 2 + i) begin
                errors++;
                $display("FAIL basic_pkt%0d: got %h at cyc %0d, expected %h at cyc %0d", i, obs_pkt[i], obs_pkt_cyc[i], exp_pkt[i], 2 + i);
            end
        end
        checks++;
        if (obs_ack.size() != 1 || obs_ack[0] != 0 || obs_ack_cyc[0] != 6) begin
            errors++;
            $display("FAIL basic_ack: got %0d acks (first cyc %0d), expected one ack of 0 at cyc 6", obs_ack.size(), (obs_ack_cyc.size() > 0) ? obs_ack_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        address_t want;
        set_basic_tables();
        want = mk_addr(32'h0001_0000);
        stall_lo = 3;
        stall_hi = 6;
        run(4'b0001, 40);
        stall_lo = 0;
        stall_hi = 0;
        for (int c = 3; c < 6; c++) begin
            checks++;
            if (valid_at[c] !== 1'b1 || dest_at[c] !== want) begin
                errors++;
                $display("FAIL stall_dest_cyc%0d: got valid=%b dest=%h, expected 1 %h", c, valid_at[c], dest_at[c], want);
            end
        end
        checks++;
        if (obs_pkt.size() != 4 || obs_pkt_cyc[1] != 6 || obs_pkt[1] !== exp_pkt[1]) begin
            errors++;
            $display("FAIL stall_pkt1: got %0d packets, pkt1 cyc %0d, expected 4 packets, pkt1 at cyc 6", obs_pkt.size(), (obs_pkt_cyc.size() > 1) ? obs_pkt_cyc[1] : -1);
        end
        checks++;
        if (timed_out || obs_ack.size() != 1 || obs_ack_cyc[0] != 9) begin
            errors++;
            $display("FAIL stall_ack: got %0d acks (first cyc %0d), expected one at cyc 9", obs_ack.size(), (obs_ack_cyc.size() > 0) ? obs_ack_cyc[0] : -1);
        end
    endtask

    task automatic test_zero_and_clamp();
        bit any_valid;
        set_basic_tables();
        num_tab[0] = 32'd0;
        run(4'b0001, 20);
        any_valid = 1'b0;
        for (int c = 0; c < 64; c++) if (valid_at[c] === 1'b1) any_valid = 1'b1;
        checks++;
        if (any_valid || obs_pkt.size() != 0) begin
            errors++;
            $display("FAIL zero_no_tx: got valid seen=%0b packets=%0d, expected none", any_valid, obs_pkt.size());
        end
        checks++;
        if (timed_out || obs_ack.size() != 1 || obs_ack_cyc[0] != 2) begin
            errors++;
            $display("FAIL zero_ack: got %0d acks (first cyc %0d), expected one at cyc 2", obs_ack.size(), (obs_ack_cyc.size() > 0) ? obs_ack_cyc[0] : -1);
        end
        num_tab[0] = 32'd9;
        run(4'b0001, 40);
        checks++;
        if (obs_pkt.size() != MT) begin
            errors++;
            $display("FAIL clamp_count: got %0d packets, expected %0d", obs_pkt.size(), MT);
        end
        for (int i = 0; i < obs_pkt.size() && i < exp_pkt.size(); i++) begin
            checks++;
            if (obs_pkt[i] !== exp_pkt[i]) begin
                errors++;
                $display("FAIL clamp_pkt%0d: got %h, expected %h", i, obs_pkt[i], exp_pkt[i]);
            end
        end
        checks++;
        if (timed_out || obs_ack.size() != 1 || obs_ack_cyc[0] != 6) begin
            errors++;
            $display("FAIL clamp_ack: got %0d acks, expected one at cyc 6", obs_ack.size());
        end
    endtask

    task automatic test_reset_mid_fanout();
        do_reset();
        set_basic_tables();
        clear_obs();
        bus_if.rts_i = 4'b0001;
        while (cyc < 4) step();
        checks++;
        if (bus_if.tx_valid_o !== 1'b1 || bus_if.tgt_idx_o !== 3'd2) begin
            errors++;
            $display("FAIL midrst_pre: got valid=%b idx=%0d, expected 1 and 2", bus_if.tx_valid_o, bus_if.tgt_idx_o);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_if.tx_valid_o !== 1'b0 || bus_if.busy_o !== 1'b0 || bus_if.rts_ack_o !== '0 || bus_if.tx_dest_o !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b busy=%b ack=%b dest=%h, expected all 0", bus_if.tx_valid_o, bus_if.busy_o, bus_if.rts_ack_o, bus_if.tx_dest_o);
        end
        step();
        step();
        checks++;
        if (obs_ack.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_ack: got %0d acks, expected 0", obs_ack.size());
        end
        reset_n = 1'b1;
        model_ptr = 0;
        run(4'b0001, 40);
        checks++;
        if (obs_pkt.size() != 4 || obs_pkt[0].dest !== mk_addr(32'h0000_0001) || obs_pkt_cyc[0] != 2) begin
            errors++;
            $display("FAIL midrst_restart: got %0d packets, first dest %h, expected 4 starting at 00000001", obs_pkt.size(), (obs_pkt.size() > 0) ? obs_pkt[0].dest : '0);
        end
        checks++;
        if (timed_out || obs_ack.size() != 1 || obs_ack_cyc[0] != 6) begin
            errors++;
            $display("FAIL midrst_ack: got %0d acks, expected one at cyc 6", obs_ack.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            num_tab[i] = 32'd1;
            pay_tab[i] = PW'($urandom());
            for (int k = 0; k < MT; k++) addr_tab[i][k] = address_t'({$urandom(), $urandom()});
        end
        run(4'b1111, 60);
        checks++;
        if (timed_out || obs_ack.size() != N) begin
            errors++;
            $display("FAIL rr_count: got %0d acks, expected %0d", obs_ack.size(), N);
        end
        for (int i = 0; i < obs_ack.size() && i < N; i++) begin
            checks++;
            if (obs_ack[i] != i || obs_ack_cyc[i] != 3 + 4 * i || obs_pkt[i] !== exp_pkt[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got req %0d at cyc %0d, expected req %0d at cyc %0d", i, obs_ack[i], obs_ack_cyc[i], i, 3 + 4 * i);
            end
        end
        run(4'b1111, 60);
        checks++;
        if (obs_ack.size() == 0 || obs_ack[0] != 0) begin
            errors++;
            $display("FAIL rr_wrap: got first grant %0d, expected 0", (obs_ack.size() > 0) ? obs_ack[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        rand_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                num_tab[i] = 32'($urandom_range(0, 6));
                pay_tab[i] = PW'($urandom());
                for (int k = 0; k < MT; k++) addr_tab[i][k] = address_t'({$urandom(), $urandom()});
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            run(mask, 400);
            checks++;
            if (timed_out || obs_pkt.size() != exp_pkt.size() || obs_ack.size() != exp_ack.size()) begin
                errors++;
                $display("FAIL rand%0d_counts: got %0d pkts %0d acks, expected %0d pkts %0d acks", it, obs_pkt.size(), obs_ack.size(), exp_pkt.size(), exp_ack.size());
            end
            for (int i = 0; i < obs_pkt.size() && i < exp_pkt.size(); i++) begin
                checks++;
                if (obs_pkt[i] !== exp_pkt[i]) begin
                    errors++;
                    $display("FAIL rand%0d_pkt%0d: got %h, expected %h", it, i, obs_pkt[i], exp_pkt[i]);
                end
            end
            for (int i = 0; i < obs_ack.size() && i < exp_ack.size(); i++) begin
                checks++;
                if (obs_ack[i] != exp_ack[i]) begin
                    errors++;
                    $display("FAIL rand%0d_ack%0d: got %0d, expected %0d", it, i, obs_ack[i], exp_ack[i]);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

`ifdef DIRCC_FANOUT_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (sent_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d, expected 0", sent_count);
        end
        for (int i = 0; i < N; i++) begin
            num_tab[i] = 32'd4;
            for (int k = 0; k < MT; k++) addr_tab[i][k] = address_t'({$urandom(), $urandom()});
        end
        run(4'b0011, 60);
        checks++;
        if (sent_count !== 32'd8) begin
            errors++;
            $display("FAIL stats_count: got %0d, expected 8", sent_count);
        end
    endtask
`endif

    initial begin
        bus_if.rts_i      = '0;
        bus_if.tx_ready_i = 1'b1;
        rand_ready = 1'b0;
        stall_lo   = 0;
        stall_hi   = 0;
        model_ptr  = 0;
        set_basic_tables();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_clamp();
        test_reset_mid_fanout();
        test_round_robin();
        test_random();
`ifdef DIRCC_FANOUT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
